// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus: independent read and write request channels
// plus registered read data, a combinational busy and a sticky error flag.
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    // Handshake: a read request is taken every cycle it is asserted (data and
    // mem_r_valid_o follow one cycle later); a write is taken in any cycle where
    // it is asserted and mem_busy_o is low, otherwise the core must hold it.
    logic              mem_enable_i;
    logic              mem_r_enable_i;
    logic [ADDR_W-1:0] mem_r_addr_i;
    logic              mem_w_enable_i;
    logic [ADDR_W-1:0] mem_w_addr_i;
    logic [31:0]       mem_data_i;
    logic [31:0]       mem_data_o;
    logic              mem_r_valid_o;
    logic              mem_busy_o;
    logic              mem_err_o;

    modport master (
        output mem_enable_i, mem_r_enable_i, mem_r_addr_i,
        output mem_w_enable_i, mem_w_addr_i, mem_data_i,
        input  mem_data_o, mem_r_valid_o, mem_busy_o, mem_err_o
    );

    modport slave (
        input  mem_enable_i, mem_r_enable_i, mem_r_addr_i,
        input  mem_w_enable_i, mem_w_addr_i, mem_data_i,
        output mem_data_o, mem_r_valid_o, mem_busy_o, mem_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word RAM behind a one-entry write buffer,
// so a read and a write in the same cycle are both serviced.
module dmem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

    logic [31:0] ram [DEPTH_WORDS];

    logic [IDX_W-1:0] r_idx, w_idx;
    logic             r_in, w_in;
    logic             r_req, w_req, w_acc, busy;

    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [31:0]      wb_data;

    logic [31:0]       data_q;
    logic              r_valid_q;
    logic              err_q;
    logic [31:0]       rd_word;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [31:0]       ram_wdata;

    assign r_idx = bus.mem_r_addr_i[ADDR_W-1:2];
    assign w_idx = bus.mem_w_addr_i[ADDR_W-1:2];
    assign r_in  = ({1'b0, r_idx} < DEPTH_L);
    assign w_in  = ({1'b0, w_idx} < DEPTH_L);

    assign r_req = bus.mem_enable_i & bus.mem_r_enable_i;
    assign w_req = bus.mem_enable_i & bus.mem_w_enable_i;

    // The RAM port is already taken by the read, so only a same-index write
    // (coalesce) or an empty buffer can absorb a concurrent write.
    assign busy  = r_req & w_req & w_in & wb_valid & (w_idx != wb_idx) & ~rst;
    assign w_acc = w_req & w_in & ~busy;

    // Forwarding uses buffer state before the edge; the RAM read sees the old word.
    always_comb begin
        rd_word = 32'h0;
        if (r_in) begin
            if (wb_valid && (wb_idx == r_idx)) rd_word = wb_data;
            else                               rd_word = ram[r_idx[RAM_AW-1:0]];
        end
    end

    // RAM write port is only free in read-free cycles: direct write or drain.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wb_idx[RAM_AW-1:0];
        ram_wdata = wb_data;
        if (!rst && !r_req) begin
            if (w_acc && !wb_valid) begin
                ram_we    = 1'b1;
                ram_waddr = w_idx[RAM_AW-1:0];
                ram_wdata = bus.mem_data_i;
            end else if (wb_valid && !(w_acc && (w_idx == wb_idx))) begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= 32'h0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
            wb_valid  <= 1'b0;
            wb_idx    <= '0;
            wb_data   <= 32'h0;
        end else begin
            r_valid_q <= r_req;
            if (r_req) data_q <= rd_word;
            if ((r_req && !r_in) || (w_req && !w_in)) err_q <= 1'b1;
            if (w_acc) begin
                // Load or coalesce; a write-only cycle with an empty buffer went straight to RAM.
                if (r_req || wb_valid) begin
                    wb_valid <= 1'b1;
                    wb_idx   <= w_idx;
                    wb_data  <= bus.mem_data_i;
                end
            end else if (!r_req && wb_valid) begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign bus.mem_data_o    = data_q;
    assign bus.mem_r_valid_o = r_valid_q;
    assign bus.mem_busy_o    = busy;
    assign bus.mem_err_o     = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a word-level memory model feeds an
// expected-read queue that is compared one cycle after each request.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32)) dut_if ();

    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024)) dut (
        .clk(clk),
        .rst(rst),
        .bus(dut_if)
    );

    int checks = 0;
    int errors = 0;

    // Entry: {check_data, expected_valid, expected_data}
    logic [33:0] exp_q[$];
    logic [31:0] model_mem [int unsigned];
    logic [33:0] mon_e;

    // Scoreboard: one entry per clock, popped just after the edge it describes.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (dut_if.mem_r_valid_o !== mon_e[32]) begin
                errors++;
                $display("FAIL r_valid: got %b expected %b at %0t", dut_if.mem_r_valid_o, mon_e[32], $time);
            end
            if (mon_e[33]) begin
                checks++;
                if (dut_if.mem_data_o !== mon_e[31:0]) begin
                    errors++;
                    $display("FAIL r_data: got %h expected %h at %0t", dut_if.mem_data_o, mon_e[31:0], $time);
                end
            end
        end
    end

    task automatic set_in(input bit en, input bit re, input logic [31:0] ra,
                          input bit we, input logic [31:0] wa, input logic [31:0] wd);
        dut_if.mem_enable_i   = en;
        dut_if.mem_r_enable_i = re;
        dut_if.mem_r_addr_i   = ra;
        dut_if.mem_w_enable_i = we;
        dut_if.mem_w_addr_i   = wa;
        dut_if.mem_data_i     = wd;
    endtask

    task automatic idle_in();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // Push this cycle's expectation, update the model, advance one clock.
    task automatic tick(input bit exp_busy);
        logic [33:0] e;
        int unsigned ri, wi;
        ri = dut_if.mem_r_addr_i >> 2;
        wi = dut_if.mem_w_addr_i >> 2;
        e  = 34'h0;
        if (rst) begin
            e = {1'b1, 1'b0, 32'h0};
        end else if (dut_if.mem_enable_i && dut_if.mem_r_enable_i) begin
            if (ri >= 1024)               e = {1'b1, 1'b1, 32'h0};
            else if (model_mem.exists(ri)) e = {1'b1, 1'b1, model_mem[ri]};
            else                          e = {1'b0, 1'b1, 32'h0};
        end
        exp_q.push_back(e);
        if (!rst && dut_if.mem_enable_i && dut_if.mem_w_enable_i && wi < 1024 && !exp_busy)
            model_mem[wi] = dut_if.mem_data_i;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 32'h55);
        tick(1'b0);
        tick(1'b0);
        checks++;
        if (dut_if.mem_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", dut_if.mem_data_o); end
        checks++;
        if (dut_if.mem_r_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dut_if.mem_r_valid_o); end
        checks++;
        if (dut_if.mem_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", dut_if.mem_err_o); end
        checks++;
        if (dut_if.mem_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", dut_if.mem_busy_o); end
        rst = 1'b0;
        idle_in();
        tick(1'b0);
    endtask

    task automatic init_mem();
        logic [31:0] addrs [8];
        addrs = '{32'h0, 32'h20, 32'h30, 32'h34, 32'h40, 32'h44, 32'h50, 32'h10};
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1, addrs[i], (i == 0) ? 32'h5A5A5A5A : 32'h0);
            tick(1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h100 + 32'(i * 4), $urandom);
            tick(1'b0);
        end
        idle_in();
        tick(1'b0);
    endtask

    task automatic test_basic_rw();
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic test_same_cycle();
        set_in(1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 32'h11111111);
        #1;
        checks++;
        if (dut_if.mem_busy_o !== 1'b0) begin errors++; $display("FAIL same_cycle_busy: got %b expected 0", dut_if.mem_busy_o); end
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
    endtask

    task automatic test_busy_conflict();
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h30, 32'hA);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h34, 32'hB);
        #1;
        checks++;
        if (dut_if.mem_busy_o !== 1'b1) begin errors++; $display("FAIL busy_conflict: got %b expected 1", dut_if.mem_busy_o); end
        tick(1'b1);
        idle_in();
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h34, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h34, 32'hB);
        #1;
        checks++;
        if (dut_if.mem_busy_o !== 1'b0) begin errors++; $display("FAIL busy_retry: got %b expected 0", dut_if.mem_busy_o); end
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h34, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
        // Write-only into a full buffer at another index drains and reloads.
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h30, 32'hA1);
        tick(1'b0);
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h34, 32'hB1);
        #1;
        checks++;
        if (dut_if.mem_busy_o !== 1'b0) begin errors++; $display("FAIL busy_write_only: got %b expected 0", dut_if.mem_busy_o); end
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h34, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
    endtask

    task automatic test_coalesce();
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h30, 32'hA);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h30, 32'hC);
        #1;
        checks++;
        if (dut_if.mem_busy_o !== 1'b0) begin errors++; $display("FAIL coalesce_busy: got %b expected 0", dut_if.mem_busy_o); end
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
    endtask

    task automatic test_out_of_range();
        checks++;
        if (dut_if.mem_err_o !== 1'b0) begin errors++; $display("FAIL oor_err_before: got %b expected 0", dut_if.mem_err_o); end
        set_in(1'b1, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        checks++;
        if (dut_if.mem_err_o !== 1'b1) begin errors++; $display("FAIL oor_err_set: got %b expected 1", dut_if.mem_err_o); end
        idle_in();
        for (int i = 0; i < 3; i++) tick(1'b0);
        checks++;
        if (dut_if.mem_err_o !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b expected 1", dut_if.mem_err_o); end
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 32'h77);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h1000, 32'h99);
        #1;
        checks++;
        if (dut_if.mem_busy_o !== 1'b0) begin errors++; $display("FAIL oor_busy: got %b expected 0", dut_if.mem_busy_o); end
        tick(1'b0);
        idle_in();
        tick(1'b0);
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h1000, 32'h33);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h44, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h50, 32'h12345678);
        tick(1'b0);
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h50, 32'hCAFEF00D);
        tick(1'b0);
        rst = 1'b1;
        idle_in();
        tick(1'b0);
        rst = 1'b0;
        // The buffered write is lost, so the architectural value reverts.
        model_mem[32'h50 >> 2] = 32'h12345678;
        checks++;
        if (dut_if.mem_err_o !== 1'b0) begin errors++; $display("FAIL reset_mid_err: got %b expected 0", dut_if.mem_err_o); end
        set_in(1'b1, 1'b1, 32'h50, 1'b0, 32'h0, 32'h0);
        tick(1'b0);
        idle_in();
        tick(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            set_in(1'b1, 1'b1, 32'h100 + 32'($urandom_range(0, 15) * 4), 1'b0, 32'h0, 32'h0);
            tick(1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: set_in(1'b1, 1'b1, 32'h100 + 32'($urandom_range(0, 15) * 4), 1'b0, 32'h0, 32'h0);
                1: set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h100 + 32'($urandom_range(0, 15) * 4), $urandom);
                default: set_in(1'b0, 1'b1, 32'h100, 1'b1, 32'h104, $urandom);
            endcase
            tick(1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 32'h0, 32'h0);
            tick(1'b0);
        end
        idle_in();
        tick(1'b0);
        tick(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        test_reset();
        init_mem();
        test_basic_rw();
        test_same_cycle();
        test_busy_conflict();
        test_coalesce();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that sits on the far side of the core's data bus and services its `mem_*` read and write requests. It holds a single-port word RAM behind a one-entry write buffer, so a read and a write presented in the same cycle are both serviced. Reads are registered (1-cycle latency) and forwarded from the write buffer on an index hit. `mem_busy_o` is provided for the pipeline controller.

## Interface
- `ADDR_W`, default 32: byte-address width of `mem_r_addr_i` and `mem_w_addr_i`.
- `DEPTH_WORDS`, default 1024: number of 32-bit RAM words; power of two not required.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_enable_i`  in  1  global request qualifier; when 0, both read and write requests are ignored.
- `mem_r_enable_i`  in  1  read request.
- `mem_r_addr_i`  in  ADDR_W  read byte address.
- `mem_w_enable_i`  in  1  write request.
- `mem_w_addr_i`  in  ADDR_W  write byte address.
- `mem_data_i`  in  32  write data from the core.
- `mem_data_o`  out  32  registered read data; holds its last value between reads.
- `mem_r_valid_o`  out  1  one-cycle pulse, `mem_data_o` updated this cycle.
- `mem_busy_o`  out  1  combinational; the current write cannot be accepted and the core must hold it.
- `mem_err_o`  out  1  sticky out-of-range access flag.

## Operation
- **Indexing.** Word index = `addr[ADDR_W-1:2]`; `addr[1:0]` is ignored. Index ≥ `DEPTH_WORDS` is out-of-range.
- **Qualified requests.** Read req R = `mem_enable_i & mem_r_enable_i`. Write req W = `mem_enable_i & mem_w_enable_i & in-range & !mem_busy_o`.
- **Write buffer.** State is `wb_valid`, `wb_idx`, `wb_data`. The RAM port performs at most one access per cycle.
- **Per-cycle port arbitration, in priority order:**
  1. R and W, buffer empty: RAM reads R; the write loads the buffer.
  2. R and W, buffer full, `w_idx == wb_idx`: RAM reads R; `wb_data` is overwritten (coalesce); `mem_busy_o=0`.
  3. R and write request, buffer full, `w_idx != wb_idx`: `mem_busy_o=1`; the write is not captured; RAM reads R; buffer is unchanged.
  4. R only: RAM reads R; buffer is unchanged.
  5. W only, buffer empty: RAM writes directly; buffer stays empty.
  6. W only, buffer full: the buffer drains to RAM and the new write loads the buffer. If `w_idx == wb_idx`, coalesce instead, with no drain.
  7. Idle with buffer full: drain to RAM; `wb_valid` ← 0.
- **Read data selection,** captured into `mem_data_o` at the edge:
  - Out-of-range read: 0.
  - Else, `wb_valid & wb_idx == r_idx`, using buffer state before this edge: `wb_data`.
  - Else: the RAM word before any same-cycle write.
  - Consequence: a same-cycle read of the index being written returns the OLD value.
- **Errors.**
  - `mem_err_o` ← 1 on any qualified read or write request to an out-of-range index.
  - It is cleared only by `rst`.
  - Out-of-range writes are dropped and never raise `mem_busy_o`.
- **Busy.** `mem_busy_o = mem_enable_i & mem_r_enable_i & mem_w_enable_i & in-range(w) & wb_valid & (w_idx != wb_idx) & !rst`.
- **Reset.**
  - Outputs on reset: `mem_data_o`=0, `mem_r_valid_o`=0, `mem_err_o`=0, `wb_valid`=0.
  - Reset mid-operation discards any buffered write; the RAM keeps its old value at that index.
  - RAM contents are not reset.
  - Requests in the reset cycle are ignored.

## Timing
- Read latency: request at cycle N → `mem_data_o` and `mem_r_valid_o=1` at cycle N+1. `mem_r_valid_o` is 0 in every cycle without a read the prior cycle.
- Back-to-back reads: one per cycle, no bubbles.
- Write visibility: a write accepted at cycle N is returned by any read requested at N+1 or later, from the buffer or from RAM.
- Buffer drain: happens in the first cycle with no read. With continuous reads the buffer never drains; coalescing or busy handles further writes.
- `mem_busy_o`: purely combinational from the current inputs and `wb_valid`/`wb_idx`. It deasserts one cycle after the first read-free cycle drains the buffer.

## Test plan
- **Reset and basic write/read.** Assert `rst` → all outputs 0. Write 0x10←0xDEADBEEF alone, then read 0x10 → next cycle `mem_data_o`=0xDEADBEEF, `mem_r_valid_o`=1 for exactly one cycle.
- **Same-cycle read/write of one index.** With 0x20=0: write 0x20←0x11111111 and read 0x20 together → data 0x00000000. Read 0x20 next cycle → 0x11111111 (buffer forward).
- **Busy on buffer conflict.** Buffer holds 0x30=0xA. Write 0x34←0xB with read 0x40 → `mem_busy_o`=1 and 0x34 is not written. Next idle cycle drains. Retry → accepted; a later read of 0x34 returns 0xB.
- **Coalesce.** Buffer holds 0x30=0xA. Write 0x30←0xC with read 0x40 → `mem_busy_o`=0. Read 0x30 → 0xC; RAM holds 0xC after drain.
- **Out-of-range access.** With `DEPTH_WORDS`=1024, read 0x1000 → data 0, valid 1, `mem_err_o`=1, staying 1 until `rst`. Write 0x1000 → no RAM change, `mem_busy_o`=0.
- **Reset mid-operation.** RAM 0x50=0x12345678; buffer holds 0x50←0xCAFEF00D; pulse `rst` for 1 cycle. Read 0x50 → 0x12345678, and `mem_err_o`=0.
